perm_seq: RTL and testbench
===========================

# perm_seq

Sequencer between the NoC interface's 200-byte block buffers and the permutation block. It streams one 25×64-bit block into the perm with pushin/firstin, honouring stopin backpressure. It then collects the 25 permuted words from pushout/firstout/dout, throttling with stopout, into the output buffer. It replaces ad-hoc perm control inside the NoC interface and owns all perm handshake timing.

## Interface

Parameters:
- WORDS, 25, 64-bit words per block (200 bytes)
- IDXW, 5, word index width; must satisfy 2^IDXW ≥ WORDS

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- load_req  in  1  input buffer holds a full block; level, held until load_ack
- load_idx  out  IDXW  word index the input buffer drives on load_word (combinational read)
- load_word  in  64  input buffer word at load_idx
- load_ack  out  1  one-cycle pulse: last word accepted by perm
- pushin  out  1  word valid to perm
- firstin  out  1  marks word 0 of a block
- din  out  64  word to perm
- stopin  in  1  perm stall; a push is accepted only on an edge with pushin=1, stopin=0
- pushout  in  1  perm output word valid
- firstout  in  1  marks perm output word 0
- dout  in  64  perm output word
- stopout  out  1  stall to perm; 1 = do not push
- unload_ready  in  1  output buffer free to receive a block
- store_we  out  1  write strobe to output buffer
- store_idx  out  IDXW  output buffer word index
- store_word  out  64  output buffer data
- block_done  out  1  one-cycle pulse: WORDS words stored
- busy  out  1  any block in flight (loading, in perm, or unloading)
- err  out  1  sticky protocol error; cleared only by rst

## Operation

- Load FSM: L_IDLE → L_PUSH → L_ACK → L_IDLE.
  - L_IDLE: on load_req (and load permitted, see Configuration), set load_idx=0 and enter L_PUSH.
  - L_PUSH: pushin=1, din=load_word at current index, firstin=1 only at index 0.
  - On an accepted push, increment load_idx. After index WORDS-1 is accepted, drop pushin and enter L_ACK.
  - L_ACK: pulse load_ack, set block_pending, return to L_IDLE.
- Unload FSM: U_IDLE → U_RECV → U_DONE → U_IDLE.
  - U_IDLE: when block_pending and unload_ready, enter U_RECV with store_idx=0.
  - U_RECV: stopout=0. Each edge with pushout=1 registers store_we=1, store_word=dout, store_idx=count, and increments count.
  - After WORDS words, enter U_DONE: stopout=1, pulse block_done, clear block_pending.
- stopout=1 in every state except U_RECV.
- firstout=1 with count≠0: set err, restart count at 0 (word stored at index 0).
- firstout=0 on the first word of a block: set err, word still stored.
- pushout=1 while stopout=1: word dropped, err set.
- Counters wrap never: indices stay within 0..WORDS-1. load_idx returns to 0 in L_IDLE.
- busy = (load state ≠ L_IDLE) | block_pending | (unload state ≠ U_IDLE).

## Timing

- Reset values: pushin 0, firstin 0, din 0, stopout 1, load_ack 0, load_idx 0, store_we 0, store_idx 0, store_word 0, block_done 0, busy 0, err 0. Both FSMs go to idle; block_pending clears.
- Reset mid-block abandons the transfer with no ack or done. Perm resynchronisation is the perm's responsibility.
- All outputs are registered except load_idx (a state register, not derived combinationally from inputs).
- Load handshake:
  - First pushin rises 1 cycle after load_req is sampled in L_IDLE.
  - While stopin=1, pushin, firstin and din hold stable.
  - Unstalled load: WORDS cycles of pushin, then load_ack 1 cycle after the last accepted edge.
- Unload:
  - stopout falls 1 cycle after entry into U_RECV.
  - store_we follows each sampled pushout by 1 cycle.
  - block_done pulses 1 cycle after the final store_we.
- Simultaneous load_ack and unload start are permitted; block_pending set has priority over clear only when both occur on the same edge under overlap.

## Configuration

- PERM_SEQ_OVERLAP_EN defined: a new load may start whenever the load FSM is idle and no block is pending, including while the unload FSM is in U_RECV. This double-buffers the perm.
- Not defined: load_req is ignored until block_done of the previous block (busy=0). Strictly one block in flight.

## Test plan

- Clean block: load_req with words 0..24 = index×0x0101…, stopin=0, perm echoes words after 10 cycles → 25 contiguous pushin, firstin only on word 0, load_ack at cycle 26, 25 store_we with matching data, block_done, err=0.
- Backpressure: stopin asserted for 3 cycles at word 7 → din holds word 7 for 4 cycles; total pushes still 25; load_ack delayed by 3.
- unload_ready low for 20 cycles after load_ack → stopout stays 1, no store_we; starts 1 cycle after unload_ready rises.
- Protocol error: firstout=1 on output word 12 → err=1, store_idx restarts at 0; spurious pushout with stopout=1 → no store_we.
- Overlap: second load_req asserted during U_RECV → with PERM_SEQ_OVERLAP_EN, pushin resumes before block_done; without the macro, first pushin only after block_done.
- Reset asserted at load word 10 → next cycle all outputs at reset values; a fresh block then completes cleanly.

Source files
------------

// File: rtl/perm_seq.sv
// -----------------------------------------------------------------------------
// perm_seq
// Sequencer between the NoC interface block buffers and the permutation block.
// A load FSM streams one WORDS x 64-bit block from the input buffer into the
// perm (pushin/firstin/din, stalled by stopin). An unload FSM then collects
// the permuted words (pushout/firstout/dout, throttled by stopout) and writes
// them into the output buffer (store_we/store_idx/store_word).
//
// Ports
//   clk, rst           clock, synchronous active-high reset
//   load_req           input buffer holds a full block (level until load_ack)
//   load_idx           word index presented to the input buffer
//   load_word          input buffer word at load_idx (combinational read)
//   load_ack           one-cycle pulse: last word accepted by the perm
//   pushin/firstin/din word stream into the perm
//   stopin             perm stall; push accepted when pushin=1 and stopin=0
//   pushout/firstout/dout  word stream out of the perm
//   stopout            stall towards the perm (1 = do not push)
//   unload_ready       output buffer can receive a block
//   store_we/store_idx/store_word  output buffer write port
//   block_done         one-cycle pulse: WORDS words stored
//   busy               a block is loading, pending in the perm, or unloading
//   err                sticky protocol error, cleared only by rst
//
// Configuration
//   PERM_SEQ_OVERLAP_EN  when defined, a new load may start while the previous
//                        block is still being unloaded (double-buffers the
//                        perm). Default: strictly one block in flight.
// -----------------------------------------------------------------------------
module perm_seq #(
    parameter int WORDS = 25,
    parameter int IDXW  = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_req,
    output logic [IDXW-1:0] load_idx,
    input  logic [63:0]     load_word,
    output logic            load_ack,
    output logic            pushin,
    output logic            firstin,
    output logic [63:0]     din,
    input  logic            stopin,
    input  logic            pushout,
    input  logic            firstout,
    input  logic [63:0]     dout,
    output logic            stopout,
    input  logic            unload_ready,
    output logic            store_we,
    output logic [IDXW-1:0] store_idx,
    output logic [63:0]     store_word,
    output logic            block_done,
    output logic            busy,
    output logic            err
);

    localparam logic [IDXW-1:0] ZERO_IDX = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] ONE_IDX  = IDXW'(1);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

    typedef enum logic [1:0] {
        L_IDLE = 2'd0,
        L_PUSH = 2'd1,
        L_ACK  = 2'd2
    } load_state_t;

    typedef enum logic [1:0] {
        U_IDLE = 2'd0,
        U_RECV = 2'd1,
        U_DONE = 2'd2
    } unload_state_t;

    load_state_t     l_state_r, l_state_n;
    unload_state_t   u_state_r, u_state_n;

    // load side: load_idx_r is the prefetch index (one ahead of the word on
    // din) because load_word is only valid for the index already presented.
    logic [IDXW-1:0] load_idx_r, load_idx_n;
    logic [IDXW-1:0] push_cnt_r, push_cnt_n;
    logic            pushin_r, pushin_n;
    logic            firstin_r, firstin_n;
    logic [63:0]     din_r, din_n;
    logic            load_ack_r, load_ack_n;

    // unload side
    logic [IDXW-1:0] rcv_cnt_r, rcv_cnt_n;
    logic            stopout_r, stopout_n;
    logic            store_we_r, store_we_n;
    logic [IDXW-1:0] store_idx_r, store_idx_n;
    logic [63:0]     store_word_r, store_word_n;
    logic            block_done_r, block_done_n;

    // shared status
    logic            pend_r, pend_n;
    logic            busy_r, busy_n;
    logic            err_r, err_n;

    logic            load_ok_s;
    logic            push_acc_s;
    logic            rcv_acc_s;
    logic            drop_err_s;
    logic            seq_err_s;
    logic            pend_set_s;
    logic            pend_clr_s;
    logic [IDXW-1:0] eff_idx_s;

`ifdef PERM_SEQ_OVERLAP_EN
    // new block may enter the perm as soon as the previous one has left the
    // pending slot, even while it is still being unloaded
    assign load_ok_s = (l_state_r == L_IDLE) && !pend_r;
`else
    // strictly one block in flight
    assign load_ok_s = (l_state_r == L_IDLE) && !pend_r && (u_state_r == U_IDLE);
`endif

    assign push_acc_s = pushin_r && !stopin;
    assign rcv_acc_s  = pushout && !stopout_r && (u_state_r == U_RECV);
    assign drop_err_s = pushout && stopout_r;
    // firstout realigns the block: that word always lands at index 0
    assign eff_idx_s  = firstout ? ZERO_IDX : rcv_cnt_r;

    // load FSM next-state and registered load-side outputs
    always_comb begin
        l_state_n  = l_state_r;
        load_idx_n = load_idx_r;
        push_cnt_n = push_cnt_r;
        pushin_n   = pushin_r;
        firstin_n  = firstin_r;
        din_n      = din_r;
        load_ack_n = 1'b0;
        pend_set_s = 1'b0;
        case (l_state_r)
            L_IDLE: begin
                if (load_req && load_ok_s) begin
                    l_state_n  = L_PUSH;
                    pushin_n   = 1'b1;
                    firstin_n  = 1'b1;
                    din_n      = load_word;
                    push_cnt_n = ZERO_IDX;
                    load_idx_n = ONE_IDX;
                end else begin
                    load_idx_n = ZERO_IDX;
                end
            end
            L_PUSH: begin
                if (push_acc_s) begin
                    if (push_cnt_r == LAST_IDX) begin
                        l_state_n  = L_ACK;
                        pushin_n   = 1'b0;
                        firstin_n  = 1'b0;
                        load_ack_n = 1'b1;
                        pend_set_s = 1'b1;
                        load_idx_n = ZERO_IDX;
                    end else begin
                        din_n      = load_word;
                        firstin_n  = 1'b0;
                        push_cnt_n = push_cnt_r + ONE_IDX;
                        // prefetch index saturates on the last word
                        load_idx_n = (load_idx_r == LAST_IDX) ? load_idx_r
                                                              : load_idx_r + ONE_IDX;
                    end
                end else begin
                    l_state_n = L_PUSH;
                end
            end
            L_ACK: begin
                l_state_n = L_IDLE;
            end
            default: begin
                l_state_n  = L_IDLE;
                pushin_n   = 1'b0;
                firstin_n  = 1'b0;
                load_idx_n = ZERO_IDX;
            end
        endcase
    end

    // unload FSM next-state and registered store-side outputs
    always_comb begin
        u_state_n    = u_state_r;
        rcv_cnt_n    = rcv_cnt_r;
        stopout_n    = 1'b1;
        store_we_n   = 1'b0;
        store_idx_n  = store_idx_r;
        store_word_n = store_word_r;
        block_done_n = 1'b0;
        pend_clr_s   = 1'b0;
        seq_err_s    = 1'b0;
        case (u_state_r)
            U_IDLE: begin
                if (pend_r && unload_ready) begin
                    u_state_n   = U_RECV;
                    rcv_cnt_n   = ZERO_IDX;
                    store_idx_n = ZERO_IDX;
`ifdef PERM_SEQ_OVERLAP_EN
                    pend_clr_s  = 1'b1;
`else
                    pend_clr_s  = 1'b0;
`endif
                end else begin
                    u_state_n = U_IDLE;
                end
            end
            U_RECV: begin
                if (rcv_acc_s) begin
                    store_we_n   = 1'b1;
                    store_word_n = dout;
                    store_idx_n  = eff_idx_s;
                    seq_err_s    = (firstout && (rcv_cnt_r != ZERO_IDX)) ||
                                   (!firstout && (rcv_cnt_r == ZERO_IDX));
                    if (eff_idx_s == LAST_IDX) begin
                        u_state_n = U_DONE;
                        stopout_n = 1'b1;
                        rcv_cnt_n = ZERO_IDX;
                    end else begin
                        stopout_n = 1'b0;
                        rcv_cnt_n = eff_idx_s + ONE_IDX;
                    end
                end else begin
                    stopout_n = 1'b0;
                end
            end
            U_DONE: begin
                u_state_n    = U_IDLE;
                block_done_n = 1'b1;
`ifdef PERM_SEQ_OVERLAP_EN
                pend_clr_s   = 1'b0;
`else
                pend_clr_s   = 1'b1;
`endif
            end
            default: begin
                u_state_n = U_IDLE;
                rcv_cnt_n = ZERO_IDX;
            end
        endcase
    end

    // pending flag (set wins over clear), sticky error and busy summary
    always_comb begin
        if (pend_set_s) begin
            pend_n = 1'b1;
        end else if (pend_clr_s) begin
            pend_n = 1'b0;
        end else begin
            pend_n = pend_r;
        end
        err_n  = err_r | seq_err_s | drop_err_s;
        busy_n = (l_state_n != L_IDLE) | pend_n | (u_state_n != U_IDLE);
    end

    // state and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            l_state_r    <= L_IDLE;
            u_state_r    <= U_IDLE;
            load_idx_r   <= ZERO_IDX;
            push_cnt_r   <= ZERO_IDX;
            pushin_r     <= 1'b0;
            firstin_r    <= 1'b0;
            din_r        <= 64'd0;
            load_ack_r   <= 1'b0;
            rcv_cnt_r    <= ZERO_IDX;
            stopout_r    <= 1'b1;
            store_we_r   <= 1'b0;
            store_idx_r  <= ZERO_IDX;
            store_word_r <= 64'd0;
            block_done_r <= 1'b0;
            pend_r       <= 1'b0;
            busy_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            l_state_r    <= l_state_n;
            u_state_r    <= u_state_n;
            load_idx_r   <= load_idx_n;
            push_cnt_r   <= push_cnt_n;
            pushin_r     <= pushin_n;
            firstin_r    <= firstin_n;
            din_r        <= din_n;
            load_ack_r   <= load_ack_n;
            rcv_cnt_r    <= rcv_cnt_n;
            stopout_r    <= stopout_n;
            store_we_r   <= store_we_n;
            store_idx_r  <= store_idx_n;
            store_word_r <= store_word_n;
            block_done_r <= block_done_n;
            pend_r       <= pend_n;
            busy_r       <= busy_n;
            err_r        <= err_n;
        end
    end

    assign load_idx   = load_idx_r;
    assign load_ack   = load_ack_r;
    assign pushin     = pushin_r;
    assign firstin    = firstin_r;
    assign din        = din_r;
    assign stopout    = stopout_r;
    assign store_we   = store_we_r;
    assign store_idx  = store_idx_r;
    assign store_word = store_word_r;
    assign block_done = block_done_r;
    assign busy       = busy_r;
    assign err        = err_r;

endmodule

// File: tb/tb_perm_seq.sv
// -----------------------------------------------------------------------------
// tb_perm_seq
// Directed bench for perm_seq. The input buffer is modelled as a combinational
// pattern lookup (word i = i * 0x0101...01); the perm is modelled as a FIFO
// with a 10-cycle latency that respects stopout. Table rows cover stalls and
// late unload_ready; hand-written sequences cover protocol errors, reset
// mid-block and back-to-back blocks (PERM_SEQ_OVERLAP_EN aware).
// -----------------------------------------------------------------------------
module tb_perm_seq;

    localparam int WORDS = 25;
    localparam int IDXW  = 5;

    logic            clk = 1'b0;
    logic            rst, load_req, load_ack, pushin, firstin, stopin;
    logic            pushout, firstout, stopout, unload_ready;
    logic            store_we, block_done, busy, err;
    logic [IDXW-1:0] load_idx, store_idx;
    logic [63:0]     load_word, din, dout, store_word;

    always #5 clk = ~clk;

    function automatic logic [63:0] pat(input int i);
        logic [63:0] b;
        b = 64'h0101010101010101;
        return b * 64'(i);
    endfunction

    assign load_word = pat(int'(load_idx));

    perm_seq #(.WORDS(WORDS), .IDXW(IDXW)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .load_idx(load_idx),
        .load_word(load_word), .load_ack(load_ack), .pushin(pushin),
        .firstin(firstin), .din(din), .stopin(stopin), .pushout(pushout),
        .firstout(firstout), .dout(dout), .stopout(stopout),
        .unload_ready(unload_ready), .store_we(store_we), .store_idx(store_idx),
        .store_word(store_word), .block_done(block_done), .busy(busy), .err(err)
    );

    typedef struct { logic [63:0] w; logic first; int rdy; } pw_t;
    typedef struct { int stall_at; int stall_len; int ud;
                     int exp_ack; int exp_fall; int exp_done; } vec_t;

    pw_t  fifo[$];
    int   n_cmp = 0, n_bad = 0;
    int   k, acc, npushcyc, nstallw, first_push_k, ack_k, nack, fall_k;
    int   nstore, done_k, ndone, out_n, din_bad, hold_bad, sbad;
    int   stall_at, stall_left, ud, force_first_at;
    bit   spur, ud_wait, req2;
    int   req2_k, push2_k, exp_push2;
    logic busy1, prev_hold, prev_firstin;
    logic [63:0] prev_din;
    logic [IDXW-1:0] st_idx[64];
    logic [63:0]     st_word[64];
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clr_stats();
        k = 0; acc = 0; npushcyc = 0; nstallw = 0; first_push_k = -1;
        ack_k = -1; nack = 0; fall_k = -1; nstore = 0; done_k = -1; ndone = 0;
        out_n = 0; din_bad = 0; hold_bad = 0; sbad = 0; stall_at = -1;
        stall_left = 0; ud = 0; ud_wait = 1'b0; force_first_at = -1; spur = 1'b0;
        prev_hold = 1'b0; busy1 = 1'b0;
        fifo.delete();
    endtask

    // one cycle: sample DUT at the negedge, then drive bench-side inputs
    task automatic step();
        pw_t e;
        @(negedge clk);
        k++;
        if (prev_hold && !(pushin && din == prev_din && firstin == prev_firstin)) hold_bad++;
        if (pushin) begin
            npushcyc++;
            if (first_push_k < 0) first_push_k = k;
            if (stall_at >= 0 && din == pat(stall_at)) nstallw++;
        end
        if (k == 1) busy1 = busy;
        if (load_ack) begin
            nack++;
            if (ack_k < 0) ack_k = k;
            load_req = 1'b0;
        end
        if (!stopout && fall_k < 0) fall_k = k;
        if (store_we) begin
            if (nstore < 64) begin
                st_idx[nstore]  = store_idx;
                st_word[nstore] = store_word;
            end
            nstore++;
        end
        if (block_done) begin
            ndone++;
            if (done_k < 0) done_k = k;
        end
        if (ud_wait && ack_k >= 0 && k == ack_k + ud) begin
            unload_ready = 1'b1;
            ud_wait = 1'b0;
        end
        if (pushin && acc == stall_at && stall_left > 0) begin
            stopin = 1'b1;
            stall_left--;
        end else begin
            stopin = 1'b0;
        end
        prev_hold = pushin && stopin;
        prev_din = din;
        prev_firstin = firstin;
        if (pushin && !stopin) begin
            if (din !== pat(acc % WORDS) || firstin !== ((acc % WORDS) == 0)) din_bad++;
            e.w = din;
            e.first = ((acc % WORDS) == 0);
            e.rdy = k + 10;
            fifo.push_back(e);
            acc++;
        end
        pushout = 1'b0;
        firstout = 1'b0;
        if (spur) begin
            pushout = 1'b1;
            dout = 64'hdead_beef;
            spur = 1'b0;
        end else if (!stopout && fifo.size() > 0 && fifo[0].rdy <= k) begin
            e = fifo.pop_front();
            pushout = 1'b1;
            dout = e.w;
            firstout = e.first || (out_n == force_first_at);
            out_n++;
        end
    endtask

    task automatic check_reset();
        check("rst_pushin", 64'(pushin), 64'd0);
        check("rst_firstin", 64'(firstin), 64'd0);
        check("rst_din", din, 64'd0);
        check("rst_stopout", 64'(stopout), 64'd1);
        check("rst_load_ack", 64'(load_ack), 64'd0);
        check("rst_load_idx", 64'(load_idx), 64'd0);
        check("rst_store_we", 64'(store_we), 64'd0);
        check("rst_store_idx", 64'(store_idx), 64'd0);
        check("rst_store_word", store_word, 64'd0);
        check("rst_block_done", 64'(block_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err), 64'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        load_req = 1'b0;
        step();
        check_reset();
        rst = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v);
        clr_stats();
        stall_at = v.stall_at;
        stall_left = v.stall_len;
        ud = v.ud;
        ud_wait = (v.ud > 0);
        unload_ready = (v.ud == 0);
        load_req = 1'b1;
        while (done_k < 0 && k < 300) step();
        step();
        step();
        for (int i = 0; i < WORDS; i++)
            if (st_idx[i] !== IDXW'(i) || st_word[i] !== pat(i)) sbad++;
        check($sformatf("v%0d_first_push", id), 64'(first_push_k), 64'd1);
        check($sformatf("v%0d_busy_loading", id), 64'(busy1), 64'd1);
        check($sformatf("v%0d_accepted", id), 64'(acc), 64'(WORDS));
        check($sformatf("v%0d_push_cycles", id), 64'(npushcyc), 64'(WORDS + v.stall_len));
        check($sformatf("v%0d_din_seq", id), 64'(din_bad), 64'd0);
        check($sformatf("v%0d_stall_hold", id), 64'(hold_bad), 64'd0);
        if (v.stall_at >= 0)
            check($sformatf("v%0d_stall_word_cycles", id), 64'(nstallw), 64'(v.stall_len + 1));
        check($sformatf("v%0d_ack_cycle", id), 64'(ack_k), 64'(v.exp_ack));
        check($sformatf("v%0d_ack_count", id), 64'(nack), 64'd1);
        check($sformatf("v%0d_stopout_fall", id), 64'(fall_k), 64'(v.exp_fall));
        check($sformatf("v%0d_stores", id), 64'(nstore), 64'(WORDS));
        check($sformatf("v%0d_store_data", id), 64'(sbad), 64'd0);
        check($sformatf("v%0d_done_cycle", id), 64'(done_k), 64'(v.exp_done));
        check($sformatf("v%0d_done_count", id), 64'(ndone), 64'd1);
        check($sformatf("v%0d_err", id), 64'(err), 64'd0);
        check($sformatf("v%0d_busy_end", id), 64'(busy), 64'd0);
        check($sformatf("v%0d_stopout_end", id), 64'(stopout), 64'd1);
    endtask

    initial begin
        // stall_at, stall_len, unload delay, expected ack / stopout fall / done cycle
        vecs[0] = '{-1, 0,  0, 26, 28, 54};
        vecs[1] = '{ 7, 3,  0, 29, 31, 57};
        vecs[2] = '{-1, 0, 20, 26, 48, 74};
        vecs[3] = '{ 0, 2,  5, 28, 35, 61};
        vecs[4] = '{24, 1,  0, 27, 29, 55};

        rst = 1'b1; load_req = 1'b0; stopin = 1'b0; pushout = 1'b0;
        firstout = 1'b0; dout = 64'd0; unload_ready = 1'b1;
        clr_stats();
        step();
        step();
        check_reset();
        rst = 1'b0;

        for (int i = 0; i < 5; i++) run_vec(i, vecs[i]);

        // firstout on output word 12: error, realign to index 0, no done
        clr_stats();
        force_first_at = 12;
        unload_ready = 1'b1;
        load_req = 1'b1;
        while (nstore < WORDS && k < 300) step();
        step();
        step();
        check("perr_err", 64'(err), 64'd1);
        check("perr_idx11", 64'(st_idx[11]), 64'd11);
        check("perr_idx12_restart", 64'(st_idx[12]), 64'd0);
        check("perr_word12", st_word[12], pat(12));
        check("perr_idx24", 64'(st_idx[24]), 64'd12);
        check("perr_no_done", 64'(ndone), 64'd0);
        do_reset();

        // pushout while stopout=1: dropped, err set
        clr_stats();
        spur = 1'b1;
        step();
        step();
        check("spur_no_store", 64'(nstore), 64'd0);
        check("spur_err", 64'(err), 64'd1);
        do_reset();

        // reset at load word 10 abandons the block; a fresh block then completes
        clr_stats();
        load_req = 1'b1;
        while (acc < 10 && k < 100) step();
        do_reset();
        check("rst_mid_no_ack", 64'(nack), 64'd0);
        run_vec(5, vecs[0]);

        // second load_req raised when stopout falls for block 1
        clr_stats();
        unload_ready = 1'b1;
        load_req = 1'b1;
        req2 = 1'b0;
        req2_k = -1;
        push2_k = -1;
        while (ndone < 2 && k < 400) begin
            step();
            if (!req2 && fall_k >= 0) begin
                load_req = 1'b1;
                req2 = 1'b1;
                req2_k = k;
            end else if (req2 && pushin && push2_k < 0 && k > req2_k) begin
                push2_k = k;
            end
        end
        step();
        step();
`ifdef PERM_SEQ_OVERLAP_EN
        exp_push2 = 29;
`else
        exp_push2 = 55;
`endif
        for (int i = 0; i < 2 * WORDS; i++)
            if (st_idx[i] !== IDXW'(i % WORDS) || st_word[i] !== pat(i % WORDS)) sbad++;
        check("ovl_second_push", 64'(push2_k), 64'(exp_push2));
        check("ovl_first_done", 64'(done_k), 64'd54);
        check("ovl_done_count", 64'(ndone), 64'd2);
        check("ovl_stores", 64'(nstore), 64'(2 * WORDS));
        check("ovl_store_data", 64'(sbad), 64'd0);
        check("ovl_din_seq", 64'(din_bad), 64'd0);
        check("ovl_err", 64'(err), 64'd0);
        check("ovl_busy_end", 64'(busy), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
